load_store_unit: RTL and testbench

// - Sits between the single-cycle core's execute stage (ALU address, rs2 data, control) and a handshaked data bus.
// - Replaces the zero-latency data memory.
// - Performs byte/half/word sizing, byte-enable generation, load sign/zero extension and alignment checking.
// - Stalls the core (holds PC and the register-file write) until the bus access completes.

---
 rtl/load_store_unit.sv | 180 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit bridging the execute stage to a handshaked data bus.
// Optional bus timeout abort enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state, state_next;
  logic        access, is_store, f3_ok, misaligned, bad;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc, lane, ext_data, rdata_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        expired, timed_out;

  assign access   = mem_read | mem_write;
  assign is_store = mem_write;

  always_comb begin
    f3_ok = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = ~is_store;
      default:                f3_ok = 1'b0;
    endcase
  end

  assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  assign bad = ~f3_ok | misaligned;

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << addr[1:0];
        wdata_calc = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << addr[1:0];
        wdata_calc = {2{wdata[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = wdata;
      end
    endcase
  end

  // Lane selection uses the offset/size captured at issue, not the live inputs.
  assign lane = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    ext_data = bus_rdata;
    case (f3_q)
      3'b000:  ext_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ext_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ext_data = {24'h0, lane[7:0]};
      3'b101:  ext_data = {16'h0, lane[15:0]};
      default: ext_data = bus_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  assign expired = (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt   <= 8'd0;
      timed_out <= 1'b0;
    end else if (state == IDLE) begin
      tmo_cnt   <= 8'd0;
      timed_out <= 1'b0;
    end else if (state == REQ && !bus_ack) begin
      tmo_cnt <= tmo_cnt + 8'd1;
      if (expired)
        timed_out <= 1'b1;
    end
  end
`else
  assign expired   = 1'b0;
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    fault      = 1'b0;
    rdata      = rdata_q;
    case (state)
      IDLE: begin
        if (access && bad) begin
          fault = 1'b1;
          rdata = 32'h0;
        end else if (access) begin
          stall      = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus_ack || expired)
          state_next = RESP;
      end
      RESP: begin
        fault      = timed_out;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (reset) begin
      stall = 1'b0;
      fault = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rdata_q   <= 32'h0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_be    <= 4'h0;
      bus_wdata <= 32'h0;
      f3_q      <= 3'b0;
      off_q     <= 2'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (access && bad) begin
            rdata_q <= 32'h0;
          end else if (access) begin
            bus_req   <= 1'b1;
            bus_we    <= is_store;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= be_calc;
            bus_wdata <= wdata_calc;
            f3_q      <= funct3;
            off_q     <= addr[1:0];
          end
        end
        REQ: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            rdata_q <= ext_data;
          end else if (expired) begin
            bus_req <= 1'b0;
            rdata_q <= 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with a behavioural reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, fault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_rdata = 32'h0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .fault(fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, 0 when funct3 is not legal for the op.
  function automatic int ref_size(input bit st, input logic [2:0] f3);
    case (f3)
      3'd0:    return 1;
      3'd1:    return 2;
      3'd2:    return 4;
      3'd4:    return st ? 0 : 1;
      3'd5:    return st ? 0 : 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off, input logic [31:0] w);
    logic [31:0] v;
    int size;
    size = ref_size(1'b0, f3);
    v = w >> (8 * off);
    if (size == 4) return w;
    if (size == 1) v = v & 32'hFF;
    else           v = v & 32'hFFFF;
    if (f3 == 3'd0 && v >= 32'h80)   v = v | 32'hFFFFFF00;
    if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rw, input int d);
    bit st;
    int size, off;
    bit bad;
    logic [31:0] exp_be, exp_wd, exp_rd;
    st   = wr;
    size = ref_size(st, f3);
    off  = int'(a % 4);
    bad  = (size == 0) || ((a % size) != 0);
    if (!bad) begin
      exp_be = ((32'd1 << size) - 1) << off;
      exp_wd = (size == 1) ? (wd & 32'hFF) * 32'h01010101 :
               (size == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
      exp_rd = ref_load(f3, off, rw);
    end else begin
      exp_be = 0; exp_wd = 0; exp_rd = 0;
    end

    @(negedge clk);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd; bus_ack = 1'b0;
    #1;
    check("idle_stall", stall, !bad);
    check("idle_fault", fault, bad);
    if (bad) begin
      check("bad_rdata", rdata, 32'h0);
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
      #1;
      check("bad_no_req", bus_req, 1'b0);
      check("bad_fault_pulse", fault, 1'b0);
      return;
    end

    for (int i = 0; i <= d; i++) begin
      @(negedge clk);
      check("req_bus_req", bus_req, 1'b1);
      check("req_stall", stall, 1'b1);
      check("req_we", bus_we, st);
      check("req_addr", bus_addr, a & 32'hFFFFFFFC);
      check("req_be", bus_be, exp_be);
      if (st) check("req_wdata", bus_wdata, exp_wd);
      if (i == d) begin
        bus_ack = 1'b1; bus_rdata = rw;
      end else begin
        bus_rdata = $urandom;
      end
    end
    @(posedge clk);
    #1;
    bus_ack = 1'b0; bus_rdata = $urandom;
    @(negedge clk);
    check("resp_stall", stall, 1'b0);
    check("resp_bus_req", bus_req, 1'b0);
    check("resp_fault", fault, 1'b0);
    check("resp_rdata", rdata, exp_rd);
    last_rdata = exp_rd;
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    check("idle_after_stall", stall, 1'b0);
    check("idle_rdata_hold", rdata, last_rdata);
  endtask

  initial begin
    reset = 1'b1;
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'd2; addr = 32'h21;
    wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    #12;
    check("rst_stall", stall, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_bus_we", bus_we, 1'b0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_be", bus_be, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    run_access(1, 0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    check("lw_const", rdata, 32'hDEADBEEF);
    run_access(1, 0, 3'd0, 32'h13, 32'h0, 32'h80FF0000, 0);
    check("lb_const", rdata, 32'hFFFFFF80);
    run_access(1, 0, 3'd4, 32'h13, 32'h0, 32'h80FF0000, 1);
    check("lbu_const", rdata, 32'h00000080);
    run_access(0, 1, 3'd1, 32'h22, 32'h1234ABCD, 32'h0, 0);
    check("sh_wdata_const", bus_wdata, 32'hABCDABCD);
    check("sh_be_const", bus_be, 32'hC);
    run_access(1, 0, 3'd2, 32'h21, 32'h0, 32'h0, 0);
    run_access(1, 1, 3'd4, 32'h20, 32'h0, 32'h0, 0);
    run_access(1, 0, 3'd5, 32'h42, 32'h0, 32'h9876F00D, 4);

    for (int n = 0; n < 60; n++) begin
      logic [2:0] f3r;
      bit rr, wr;
      f3r = 3'($urandom_range(0, 7));
      wr  = 1'($urandom_range(0, 1));
      rr  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      run_access(rr, wr, f3r, $urandom, $urandom, $urandom, $urandom_range(0, 3));
    end

    // Reset while a request is outstanding, then a stray ack.
    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'd2; addr = 32'h80;
    @(negedge clk);
    check("pre_rst_req", bus_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_req", bus_req, 1'b0);
    check("async_rst_stall", stall, 1'b0);
    @(negedge clk);
    reset = 1'b0; mem_read = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h12345678;
    @(negedge clk);
    check("stray_ack_req", bus_req, 1'b0);
    check("stray_ack_stall", stall, 1'b0);
    check("stray_ack_rdata", rdata, 32'h0);
    @(negedge clk);
    bus_ack = 1'b0;
    check("stray_ack_rdata2", rdata, 32'h0);

    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'd2; addr = 32'h40;
`ifdef LSU_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("tmo_req", bus_req, 1'b1);
      check("tmo_stall", stall, 1'b1);
    end
    @(negedge clk);
    check("tmo_resp_fault", fault, 1'b1);
    check("tmo_resp_rdata", rdata, 32'h0);
    check("tmo_resp_req", bus_req, 1'b0);
    check("tmo_resp_stall", stall, 1'b0);
    mem_read = 1'b0;
    @(negedge clk);
    check("tmo_fault_pulse", fault, 1'b0);
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("noack_req", bus_req, 1'b1);
      check("noack_stall", stall, 1'b1);
      check("noack_fault", fault, 1'b0);
    end
    bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 bus_ack = 1'b0;
    @(negedge clk);
    check("noack_resp_rdata", rdata, 32'hCAFEF00D);
    check("noack_resp_fault", fault, 1'b0);
    mem_read = 1'b0;
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
